bank_cmd_scheduler: RTL and testbench

Open-page command sequencer placed between the request queue and command_sender.
- Accepts one decoded DRAM request at a time: bank group, bank, row, column, read/write.
- Tracks the open row of every bank.
- Emits the ACTIVATE / PRECHARGE / READ / WRITE command stream with the required inter-command spacing.
- Command outputs drive the command_sender inputs of the same names directly.

---
 rtl/bank_cmd_scheduler.sv | 255 +++++++++++++++++++++++++
 tb/tb_bank_cmd_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bank_cmd_scheduler.sv
// bank_cmd_scheduler
// Open-page DRAM command sequencer. It sits between the request queue and
// command_sender. It accepts one decoded request at a time and tracks the open
// row of every bank. It then emits the PRECHARGE / ACTIVATE / READ / WRITE
// sequence for that request, with the required spacing between commands.
//
// Optional feature macro: BANK_SCHED_CLOSED_PAGE_EN
//   When defined, every request ends with an automatic PRECHARGE of its bank.
//   Each access is therefore a closed-bank access: ACT, column command, PRE.
//   When undefined, rows stay open after an access (open-page).
//
// Ports:
//   clk_in          clock
//   rst_N_in        asynchronous active-low reset
//   req_valid_in    request present
//   req_ready_out   scheduler idle and able to accept (combinational)
//   req_write_in    1=write, 0=read
//   req_bg_in       bank group of the request
//   req_ba_in       bank within the group
//   req_row_in      row address
//   req_col_in      column address
//   cmd_out         0=READ 1=WRITE 2=ACTIVATE 3=PRECHARGE 7=NOP (registered)
//   valid_out       cmd_out carries a real command this cycle (registered)
//   bank_group_out  latched bank group of the request in flight
//   bank_out        latched bank of the request in flight
//   row_out         latched row
//   col_out         latched column
//   busy_out        a request is in flight (registered)

module bank_cmd_scheduler #(
  parameter int BANK_GROUPS        = 4,
  parameter int BANKS_PER_GROUP    = 2,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int BURST_CYCLES       = 8
) (
  input  logic                               clk_in,
  input  logic                               rst_N_in,
  input  logic                               req_valid_in,
  output logic                               req_ready_out,
  input  logic                               req_write_in,
  input  logic [$clog2(BANK_GROUPS)-1:0]     req_bg_in,
  input  logic [$clog2(BANKS_PER_GROUP)-1:0] req_ba_in,
  input  logic [ROW_BITS-1:0]                req_row_in,
  input  logic [COL_BITS-1:0]                req_col_in,
  output logic [2:0]                         cmd_out,
  output logic                               valid_out,
  output logic [$clog2(BANK_GROUPS)-1:0]     bank_group_out,
  output logic [$clog2(BANKS_PER_GROUP)-1:0] bank_out,
  output logic [ROW_BITS-1:0]                row_out,
  output logic [COL_BITS-1:0]                col_out,
  output logic                               busy_out
);

  localparam int BG_W   = $clog2(BANK_GROUPS);
  localparam int BA_W   = $clog2(BANKS_PER_GROUP);
  localparam int NBANK  = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int IDX_W  = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int MAX_LAT_A = (PRECHARGE_LATENCY > ACTIVATION_LATENCY) ?
                             PRECHARGE_LATENCY : ACTIVATION_LATENCY;
  localparam int MAX_LAT = (MAX_LAT_A > BURST_CYCLES) ? MAX_LAT_A : BURST_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  localparam logic [2:0] CMD_READ  = 3'd0;
  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_ACT   = 3'd2;
  localparam logic [2:0] CMD_PRE   = 3'd3;
  localparam logic [2:0] CMD_NOP   = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    PRE_WAIT,
    ACT,
    ACT_WAIT,
    COL,
    RECOVER
`ifdef BANK_SCHED_CLOSED_PAGE_EN
    , AUTO_PRE
`endif
  } state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic                 accept;
  logic [IDX_W-1:0]     req_idx;

  logic                 lat_write;
  logic [BG_W-1:0]      lat_bg;
  logic [BA_W-1:0]      lat_ba;
  logic [ROW_BITS-1:0]  lat_row;
  logic [COL_BITS-1:0]  lat_col;
  logic [IDX_W-1:0]     lat_idx;

  logic                 open_q [NBANK];
  logic [ROW_BITS-1:0]  row_q  [NBANK];

  logic [2:0]           cmd_d;
  logic                 valid_d;

  assign req_ready_out = (state == IDLE);
  assign accept        = req_valid_in && req_ready_out;
  assign req_idx       = IDX_W'(req_bg_in) * IDX_W'(BANKS_PER_GROUP) + IDX_W'(req_ba_in);

  // Next-state logic and the command for the current state. The wait counter
  // is loaded with latency-2 when a wait state is entered. The wait state then
  // lasts latency-1 cycles, so the following command lands exactly `latency`
  // cycles after the one that started the wait.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cmd_d      = CMD_NOP;
    valid_d    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (open_q[req_idx] && (row_q[req_idx] == req_row_in)) begin
            state_next = COL;
          end else if (open_q[req_idx]) begin
            state_next = PRE;
          end else begin
            state_next = ACT;
          end
        end
      end
      PRE: begin
        cmd_d      = CMD_PRE;
        valid_d    = 1'b1;
        state_next = PRE_WAIT;
        cnt_next   = CNT_W'(PRECHARGE_LATENCY - 2);
      end
      PRE_WAIT: begin
        if (cnt == '0) begin
`ifdef BANK_SCHED_CLOSED_PAGE_EN
          // Banks are always closed between requests, so this wait only ever
          // follows the automatic precharge.
          state_next = IDLE;
`else
          state_next = ACT;
`endif
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ACT: begin
        cmd_d      = CMD_ACT;
        valid_d    = 1'b1;
        state_next = ACT_WAIT;
        cnt_next   = CNT_W'(ACTIVATION_LATENCY - 2);
      end
      ACT_WAIT: begin
        if (cnt == '0) begin
          state_next = COL;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      COL: begin
        cmd_d      = lat_write ? CMD_WRITE : CMD_READ;
        valid_d    = 1'b1;
        state_next = RECOVER;
        cnt_next   = CNT_W'(BURST_CYCLES - 2);
      end
      RECOVER: begin
        if (cnt == '0) begin
`ifdef BANK_SCHED_CLOSED_PAGE_EN
          state_next = AUTO_PRE;
`else
          state_next = IDLE;
`endif
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
`ifdef BANK_SCHED_CLOSED_PAGE_EN
      AUTO_PRE: begin
        cmd_d      = CMD_PRE;
        valid_d    = 1'b1;
        state_next = PRE_WAIT;
        cnt_next   = CNT_W'(PRECHARGE_LATENCY - 2);
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, request latch, open-row table and registered outputs. A command
  // appears on the outputs in the cycle after the FSM sits in its state. That
  // delay gives the one-cycle latency from acceptance to the first command.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state          <= IDLE;
      cnt            <= '0;
      lat_write      <= 1'b0;
      lat_bg         <= '0;
      lat_ba         <= '0;
      lat_row        <= '0;
      lat_col        <= '0;
      lat_idx        <= '0;
      for (int i = 0; i < NBANK; i++) begin
        open_q[i] <= 1'b0;
        row_q[i]  <= '0;
      end
      cmd_out        <= CMD_NOP;
      valid_out      <= 1'b0;
      bank_group_out <= '0;
      bank_out       <= '0;
      row_out        <= '0;
      col_out        <= '0;
      busy_out       <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        lat_write <= req_write_in;
        lat_bg    <= req_bg_in;
        lat_ba    <= req_ba_in;
        lat_row   <= req_row_in;
        lat_col   <= req_col_in;
        lat_idx   <= req_idx;
      end
      if (state == PRE) begin
        open_q[lat_idx] <= 1'b0;
      end
`ifdef BANK_SCHED_CLOSED_PAGE_EN
      if (state == AUTO_PRE) begin
        open_q[lat_idx] <= 1'b0;
      end
`endif
      if (state == ACT) begin
        open_q[lat_idx] <= 1'b1;
        row_q[lat_idx]  <= lat_row;
      end
      cmd_out   <= cmd_d;
      valid_out <= valid_d;
      busy_out  <= (state_next != IDLE);
      if (state != IDLE) begin
        bank_group_out <= lat_bg;
        bank_out       <= lat_ba;
        row_out        <= lat_row;
        col_out        <= lat_col;
      end else begin
        bank_group_out <= '0;
        bank_out       <= '0;
        row_out        <= '0;
        col_out        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// tb_bank_cmd_scheduler
// Directed bench for bank_cmd_scheduler. The stimulus task pushes the
// hand-derived command stream of each request into a queue. A monitor on the
// falling edge pops and compares every valid command, including its cycle.
// Build with +define+BANK_SCHED_CLOSED_PAGE_EN for the closed-page sequence.

module tb_bank_cmd_scheduler;

  localparam int HIT      = 0;
  localparam int CLOSED   = 1;
  localparam int CONFLICT = 2;

  logic       clk_in = 1'b0;
  logic       rst_N_in = 1'b0;
  logic       req_valid_in = 1'b0;
  logic       req_ready_out;
  logic       req_write_in = 1'b0;
  logic [1:0] req_bg_in = '0;
  logic       req_ba_in = 1'b0;
  logic [7:0] req_row_in = '0;
  logic [3:0] req_col_in = '0;
  logic [2:0] cmd_out;
  logic       valid_out;
  logic [1:0] bank_group_out;
  logic       bank_out;
  logic [7:0] row_out;
  logic [3:0] col_out;
  logic       busy_out;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int acc;

  typedef struct {
    int         cyc;
    logic [2:0] cmd;
    logic [1:0] bg;
    logic       ba;
    logic [7:0] row;
    logic [3:0] col;
  } exp_t;

  exp_t exp_q[$];

  bank_cmd_scheduler dut (
    .clk_in         (clk_in),
    .rst_N_in       (rst_N_in),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .req_write_in   (req_write_in),
    .req_bg_in      (req_bg_in),
    .req_ba_in      (req_ba_in),
    .req_row_in     (req_row_in),
    .req_col_in     (req_col_in),
    .cmd_out        (cmd_out),
    .valid_out      (valid_out),
    .bank_group_out (bank_group_out),
    .bank_out       (bank_out),
    .row_out        (row_out),
    .col_out        (col_out),
    .busy_out       (busy_out)
  );

  // Free-running clock plus a cycle index: period N follows rising edge N.
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushExp(input int c, input logic [2:0] cmd, input logic [1:0] bg,
                         input logic ba, input logic [7:0] row, input logic [3:0] col);
    exp_t e;
    e.cyc = c; e.cmd = cmd; e.bg = bg; e.ba = ba; e.row = row; e.col = col;
    exp_q.push_back(e);
  endtask

  // Monitor: every valid command must be the next expected one, in the
  // expected cycle. Outside commands the bus must read NOP.
  always @(negedge clk_in) begin
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", {31'd0, valid_out}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("cmd_cycle", cyc, e.cyc);
        checkOutput("cmd", {29'd0, cmd_out}, {29'd0, e.cmd});
        checkOutput("cmd_bg", {30'd0, bank_group_out}, {30'd0, e.bg});
        checkOutput("cmd_ba", {31'd0, bank_out}, {31'd0, e.ba});
        if (e.cmd == 3'd2) checkOutput("act_row", {24'd0, row_out}, {24'd0, e.row});
        if (e.cmd <= 3'd1) checkOutput("col_addr", {28'd0, col_out}, {28'd0, e.col});
      end
    end else begin
      checkOutput("nop_when_invalid", {29'd0, cmd_out}, 32'd7);
    end
  end

  // Issue one request and push its expected command stream relative to the
  // acceptance edge. With spam > 0, a different request is held valid during
  // the busy window; it must be ignored.
  task automatic applyStimulus(input logic wr, input logic [1:0] bg, input logic ba,
                               input logic [7:0] row, input logic [3:0] col,
                               input int kind, input int spam, input bit wait_ready,
                               output int acc_cyc);
    int guard;
    int exp_ready;
    @(negedge clk_in);
    req_valid_in = 1'b1;
    req_write_in = wr;
    req_bg_in    = bg;
    req_ba_in    = ba;
    req_row_in   = row;
    req_col_in   = col;
    guard = 0;
    while (!req_ready_out && guard < 200) begin
      @(negedge clk_in);
      guard++;
    end
    if (guard >= 200) checkOutput("accept_timeout", {31'd0, req_ready_out}, 32'd1);
    @(negedge clk_in);
    acc_cyc = cyc;
    if (spam > 0) begin
      req_bg_in  = 2'd3;
      req_ba_in  = 1'b1;
      req_row_in = 8'hAA;
      req_col_in = 4'hF;
    end else begin
      req_valid_in = 1'b0;
    end
`ifdef BANK_SCHED_CLOSED_PAGE_EN
    pushExp(acc_cyc + 1,  3'd2, bg, ba, row, col);
    pushExp(acc_cyc + 9,  {2'b00, wr}, bg, ba, row, col);
    pushExp(acc_cyc + 17, 3'd3, bg, ba, row, col);
    exp_ready = 21;
`else
    if (kind == HIT) begin
      pushExp(acc_cyc + 1, {2'b00, wr}, bg, ba, row, col);
      exp_ready = 8;
    end else if (kind == CLOSED) begin
      pushExp(acc_cyc + 1, 3'd2, bg, ba, row, col);
      pushExp(acc_cyc + 9, {2'b00, wr}, bg, ba, row, col);
      exp_ready = 16;
    end else begin
      pushExp(acc_cyc + 1,  3'd3, bg, ba, row, col);
      pushExp(acc_cyc + 6,  3'd2, bg, ba, row, col);
      pushExp(acc_cyc + 14, {2'b00, wr}, bg, ba, row, col);
      exp_ready = 21;
    end
`endif
    for (int i = 0; i < spam; i++) @(negedge clk_in);
    req_valid_in = 1'b0;
    if (wait_ready) begin
      while (!req_ready_out && (cyc - acc_cyc) < 100) @(negedge clk_in);
      checkOutput("ready_latency", cyc - acc_cyc, exp_ready);
      checkOutput("busy_clear", {31'd0, busy_out}, 32'd0);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cmd"},   {29'd0, cmd_out}, 32'd7);
    checkOutput({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
    checkOutput({tag, "_busy"},  {31'd0, busy_out}, 32'd0);
    checkOutput({tag, "_ready"}, {31'd0, req_ready_out}, 32'd1);
    checkOutput({tag, "_bg"},    {30'd0, bank_group_out}, 32'd0);
    checkOutput({tag, "_row"},   {24'd0, row_out}, 32'd0);
    checkOutput({tag, "_col"},   {28'd0, col_out}, 32'd0);
  endtask

  // Watchdog so the bench always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    #12;
    checkResetOutputs("reset");
    #10 rst_N_in = 1'b1;
`ifdef BANK_SCHED_CLOSED_PAGE_EN
    applyStimulus(1'b0, 2'd0, 1'b0, 8'h12, 4'd3, CLOSED, 0, 1'b1, acc);
    applyStimulus(1'b0, 2'd0, 1'b0, 8'h12, 4'd4, CLOSED, 0, 1'b1, acc);
`else
    applyStimulus(1'b0, 2'd1, 1'b0, 8'h12, 4'd3, CLOSED,   0, 1'b1, acc);
    applyStimulus(1'b1, 2'd1, 1'b0, 8'h12, 4'd5, HIT,      0, 1'b1, acc);
    applyStimulus(1'b0, 2'd1, 1'b0, 8'h34, 4'd9, CONFLICT, 0, 1'b1, acc);
    applyStimulus(1'b0, 2'd2, 1'b1, 8'h07, 4'd1, CLOSED,   0, 1'b1, acc);
    applyStimulus(1'b0, 2'd1, 1'b0, 8'h34, 4'd2, HIT,      0, 1'b1, acc);
    // Reset during ACT_WAIT drops the request and closes every bank.
    applyStimulus(1'b0, 2'd0, 1'b0, 8'h55, 4'd6, CLOSED,   0, 1'b0, acc);
    while (cyc < acc + 4) @(negedge clk_in);
    #2 rst_N_in = 1'b0;
    exp_q.delete();
    #1 checkResetOutputs("midreset");
    @(negedge clk_in);
    #2 rst_N_in = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 8'h55, 4'd6, CLOSED,   5, 1'b1, acc);
    // Bank 2 was cleared by the reset, so the open row 0x34 is gone.
    applyStimulus(1'b0, 2'd1, 1'b0, 8'h34, 4'd2, CLOSED,   0, 1'b1, acc);
`endif
    repeat (12) @(negedge clk_in);
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
